// File: rtl/uart_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// uart_cmd_ctrl
//
// Sits between the UART byte receiver and the MP3 player control logic.
// It collects 4-byte command frames (header, command, argument, checksum)
// and checks each one. Every good command is offered to the player over a
// valid/ready handshake. The block also applies an inter-byte timeout and
// keeps a saturating count of malformed, timed-out and dropped frames.
//
// Optional feature:
//   UART_CMD_CHKSUM_EN  When defined, the checksum byte is compared with
//                       (cmd + arg) mod 256, and a mismatch is an error.
//                       When undefined, the checksum byte is still consumed
//                       but never compared.
//
// Parameters:
//   TIMEOUT_CYC  maximum CLK cycles allowed between bytes inside a frame
//   HDR          frame header byte
//
// Ports:
//   CLK        in   1  system clock
//   RST        in   1  asynchronous, active-high reset
//   RX_DATA    in   8  received byte, qualified by RX_VALID
//   RX_VALID   in   1  one-cycle strobe per received byte
//   CMD        out  4  command code, stable while CMD_VALID is high
//   ARG        out  8  command argument, stable while CMD_VALID is high
//   CMD_VALID  out  1  a command is being offered
//   CMD_READY  in   1  the consumer accepts the command
//   BUSY       out  1  high whenever the parser is not idle
//   ERR_CNT    out  8  saturating error counter
//
// Handshake: CMD_VALID is high for the whole OUT state, and CMD/ARG do not
// change while it is high. A transfer happens in any cycle where CMD_VALID
// and CMD_READY are both high. CMD_VALID drops in the next cycle. CMD_VALID
// never depends on CMD_READY inside the same cycle.
// -----------------------------------------------------------------------------
module uart_cmd_ctrl #(
    parameter int          TIMEOUT_CYC = 208340,
    parameter logic [7:0]  HDR         = 8'hAA
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] RX_DATA,
    input  logic       RX_VALID,
    output logic [3:0] CMD,
    output logic [7:0] ARG,
    output logic       CMD_VALID,
    input  logic       CMD_READY,
    output logic       BUSY,
    output logic [7:0] ERR_CNT
);

    localparam int            TW       = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GET_CMD = 3'd1,
        GET_ARG = 3'd2,
        GET_SUM = 3'd3,
        OUT     = 3'd4
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [3:0]    cmd_lat;
    logic [7:0]    arg_lat;
    logic [TW-1:0] tmo_cnt;
    logic          in_frame;
    logic          timeout;
    logic          sum_ok;
    logic          err_evt;
    logic          ld_cmd;
    logic          ld_arg;
    logic          ld_out;

    assign in_frame = (state == GET_CMD) || (state == GET_ARG) || (state == GET_SUM);

    // The counter is cleared on the edge that samples a strobe, so it reads
    // k-1 in the k-th cycle after that strobe. Reaching TMO_LAST therefore
    // marks the cycle that lies exactly TIMEOUT_CYC cycles after the last byte.
    // A byte that arrives in that same cycle still wins.
    assign timeout = in_frame && !RX_VALID && (tmo_cnt == TMO_LAST);

`ifdef UART_CMD_CHKSUM_EN
    logic [7:0] chk_sum;
    // The sum is 8 bits wide, so the carry is dropped.
    assign chk_sum = {4'h0, cmd_lat} + arg_lat;
    assign sum_ok  = (RX_DATA == chk_sum);
`else
    assign sum_ok  = 1'b1;
`endif

    assign BUSY      = (state != IDLE);
    assign CMD_VALID = (state == OUT);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        err_evt    = 1'b0;
        ld_cmd     = 1'b0;
        ld_arg     = 1'b0;
        ld_out     = 1'b0;
        case (state)
            IDLE: begin
                // Non-header bytes between frames are ignored, not counted.
                if (RX_VALID && (RX_DATA == HDR)) begin
                    next_state = GET_CMD;
                end
            end
            GET_CMD: begin
                // A repeated header lands here as a command byte and is rejected.
                // The parser does not try to resynchronise mid-frame.
                if (RX_VALID) begin
                    if (RX_DATA > 8'h0F) begin
                        err_evt    = 1'b1;
                        next_state = IDLE;
                    end else begin
                        ld_cmd     = 1'b1;
                        next_state = GET_ARG;
                    end
                end else if (timeout) begin
                    err_evt    = 1'b1;
                    next_state = IDLE;
                end
            end
            GET_ARG: begin
                if (RX_VALID) begin
                    ld_arg     = 1'b1;
                    next_state = GET_SUM;
                end else if (timeout) begin
                    err_evt    = 1'b1;
                    next_state = IDLE;
                end
            end
            GET_SUM: begin
                if (RX_VALID) begin
                    if (sum_ok) begin
                        ld_out     = 1'b1;
                        next_state = OUT;
                    end else begin
                        err_evt    = 1'b1;
                        next_state = IDLE;
                    end
                end else if (timeout) begin
                    err_evt    = 1'b1;
                    next_state = IDLE;
                end
            end
            OUT: begin
                // Bytes that arrive while a command is pending are overruns.
                if (RX_VALID) begin
                    err_evt = 1'b1;
                end
                if (CMD_READY) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tmo_cnt <= '0;
        end else if (!in_frame || RX_VALID || timeout) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cmd_lat <= 4'h0;
            arg_lat <= 8'h00;
            CMD     <= 4'h0;
            ARG     <= 8'h00;
        end else begin
            if (ld_cmd) begin
                cmd_lat <= RX_DATA[3:0];
            end
            if (ld_arg) begin
                arg_lat <= RX_DATA;
            end
            if (ld_out) begin
                CMD <= cmd_lat;
                ARG <= arg_lat;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ERR_CNT <= 8'h00;
        end else if (err_evt && (ERR_CNT != 8'hFF)) begin
            ERR_CNT <= ERR_CNT + 8'h01;
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
module tb_uart_cmd_ctrl;

  localparam int TMO = 20;

  logic       CLK;
  logic       RST;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic [3:0] CMD;
  logic [7:0] ARG;
  logic       CMD_VALID;
  logic       CMD_READY;
  logic       BUSY;
  logic [7:0] ERR_CNT;

  int checks = 0;
  int errors = 0;
  int pushed = 0;
  int xfers  = 0;
  logic [7:0]  exp_err;
  logic [11:0] exp_q[$];

  uart_cmd_ctrl #(.TIMEOUT_CYC(TMO), .HDR(8'hAA)) dut (
    .CLK(CLK), .RST(RST), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .CMD(CMD), .ARG(ARG), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .BUSY(BUSY), .ERR_CNT(ERR_CNT)
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] bump(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'h01;
  endfunction

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    @(posedge CLK);
    #1;
    RX_DATA  = b;
    RX_VALID = 1'b1;
    @(posedge CLK);
    #1;
    RX_VALID = 1'b0;
    RX_DATA  = 8'h00;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] s);
    send_byte(8'hAA);
    send_byte(c);
    send_byte(a);
    send_byte(s);
  endtask

  task automatic push_exp(input logic [3:0] c, input logic [7:0] a);
    exp_q.push_back({c, a});
    pushed++;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // scoreboard: every transfer pops one expected command
  always @(negedge CLK) begin
    if (!RST && CMD_VALID && CMD_READY) begin
      xfers++;
      if (exp_q.size() > 0) begin
        logic [11:0] e;
        e = exp_q.pop_front();
        check_eq("sb_cmd_arg", {20'h0, CMD, ARG}, {20'h0, e});
      end
    end
  end

  initial begin
    logic [3:0] c;
    logic [7:0] a;
    RST       = 1'b1;
    RX_DATA   = 8'h00;
    RX_VALID  = 1'b0;
    CMD_READY = 1'b1;
    exp_err   = 8'h00;
    idle(3);
    check_eq("rst_cmd", {28'h0, CMD}, 0);
    check_eq("rst_arg", {24'h0, ARG}, 0);
    check_eq("rst_valid", {31'h0, CMD_VALID}, 0);
    check_eq("rst_busy", {31'h0, BUSY}, 0);
    check_eq("rst_err", {24'h0, ERR_CNT}, 0);
    RST = 1'b0;
    idle(2);

    // basic frame, ready already high: one-cycle valid pulse
    push_exp(4'h3, 8'h10);
    send_byte(8'hAA);
    check_eq("busy_after_hdr", {31'h0, BUSY}, 1);
    send_byte(8'h03);
    send_byte(8'h10);
    send_byte(8'h13);
    check_eq("valid_rise", {31'h0, CMD_VALID}, 1);
    check_eq("cmd_3", {28'h0, CMD}, 3);
    check_eq("arg_10", {24'h0, ARG}, 32'h10);
    idle(1);
    check_eq("valid_pulse_end", {31'h0, CMD_VALID}, 0);
    check_eq("err_after_good", {24'h0, ERR_CNT}, {24'h0, exp_err});

    // bad checksum frame
`ifdef UART_CMD_CHKSUM_EN
    exp_err = bump(exp_err);
`else
    push_exp(4'h5, 8'h20);
`endif
    send_frame(8'h05, 8'h20, 8'h00);
    idle(2);
    check_eq("err_chksum", {24'h0, ERR_CNT}, {24'h0, exp_err});

    // leading junk ignored, bad command code, trailing junk ignored
    send_byte(8'h55);
    check_eq("busy_junk", {31'h0, BUSY}, 0);
    send_byte(8'hAA);
    send_byte(8'h1F);
    exp_err = bump(exp_err);
    check_eq("err_badcmd", {24'h0, ERR_CNT}, {24'h0, exp_err});
    check_eq("busy_badcmd", {31'h0, BUSY}, 0);
    send_byte(8'h00);
    send_byte(8'h00);
    check_eq("err_trailing", {24'h0, ERR_CNT}, {24'h0, exp_err});
    check_eq("busy_trailing", {31'h0, BUSY}, 0);

    // inter-byte timeout: fires TMO cycles after the 02 strobe
    send_byte(8'hAA);
    send_byte(8'h02);
    idle(TMO - 1);
    check_eq("tmo_busy_before", {31'h0, BUSY}, 1);
    check_eq("tmo_err_before", {24'h0, ERR_CNT}, {24'h0, exp_err});
    idle(1);
    exp_err = bump(exp_err);
    check_eq("tmo_busy_after", {31'h0, BUSY}, 0);
    check_eq("tmo_err_after", {24'h0, ERR_CNT}, {24'h0, exp_err});

    // held command with overruns
    CMD_READY = 1'b0;
    push_exp(4'h7, 8'h42);
    send_frame(8'h07, 8'h42, 8'h49);
    send_byte(8'hAA);
    send_byte(8'h01);
    send_byte(8'h02);
    repeat (3) exp_err = bump(exp_err);
    check_eq("hold_valid", {31'h0, CMD_VALID}, 1);
    check_eq("hold_cmd", {28'h0, CMD}, 7);
    check_eq("hold_arg", {24'h0, ARG}, 32'h42);
    check_eq("overrun_err", {24'h0, ERR_CNT}, {24'h0, exp_err});
    CMD_READY = 1'b1;
    idle(1);
    check_eq("hold_release", {31'h0, CMD_VALID}, 0);

    // random good frames
    for (int i = 0; i < 8; i++) begin
      c = 4'($urandom_range(0, 15));
      a = 8'($urandom_range(0, 255));
      push_exp(c, a);
      send_frame({4'h0, c}, a, {4'h0, c} + a);
      idle(2);
    end
    check_eq("err_random_good", {24'h0, ERR_CNT}, {24'h0, exp_err});

    // saturation
    for (int i = 0; i < 300; i++) begin
      send_byte(8'hAA);
      send_byte(8'($urandom_range(16, 255)));
      exp_err = bump(exp_err);
    end
    check_eq("err_saturate", {24'h0, ERR_CNT}, {24'h0, exp_err});
    check_eq("err_is_ff", {24'h0, ERR_CNT}, 32'hFF);

    // reset in GET_ARG
    send_byte(8'hAA);
    send_byte(8'h03);
    check_eq("busy_pre_rst", {31'h0, BUSY}, 1);
    RST = 1'b1;
    #2;
    exp_err = 8'h00;
    check_eq("mid_rst_busy", {31'h0, BUSY}, 0);
    check_eq("mid_rst_err", {24'h0, ERR_CNT}, 0);
    check_eq("mid_rst_cmd", {28'h0, CMD}, 0);
    check_eq("mid_rst_arg", {24'h0, ARG}, 0);
    check_eq("mid_rst_valid", {31'h0, CMD_VALID}, 0);
    idle(2);
    RST = 1'b0;
    idle(1);
    push_exp(4'hC, 8'hF8);
    send_frame(8'h0C, 8'hF8, 8'h04);
    check_eq("post_rst_valid", {31'h0, CMD_VALID}, 1);
    idle(2);
    check_eq("post_rst_err", {24'h0, ERR_CNT}, {24'h0, exp_err});

    idle(2);
    check_eq("sb_drain", exp_q.size(), 0);
    check_eq("xfer_count", xfers, pushed);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
